// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART settings used by uart_rx, uart_tx and uart_rx_fifo
package uart_pkg;
   localparam int UART_DATA_W = 8;
   localparam int CLK_HZ      = 100_000_000;
   localparam int BIT_RATE    = 9600;
endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-byte FIFO between uart_rx and the uart_tx path
// Optional saturating dropped-byte counter enabled by UART_RX_FIFO_OVR_CNT_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W    = UART_DATA_W,
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = 12
) (
   input  logic                       clk_i,
   input  logic                       nreset_i,
   input  logic                       wr_en_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   output logic                       rd_valid_o,
   input  logic                       rd_ready_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       afull_o,
   output logic                       overrun_o,
   output logic [7:0]                 ovr_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     level_q, level_d;
   logic              overrun_q, overrun_d;
   logic              empty, full, rd_fire, wr_accept;

   // A read frees a slot in the same cycle, so a full FIFO still takes the write.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
      rd_fire   = !empty && rd_ready_i;
      wr_accept = wr_en_i && (!full || rd_fire);
      overrun_d = wr_en_i && full && !rd_fire;
      wr_ptr_d  = wr_ptr_q + (wr_accept ? PW'(1) : PW'(0));
      rd_ptr_d  = rd_ptr_q + (rd_fire ? PW'(1) : PW'(0));
      level_d   = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (nreset_i && wr_accept) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   // Storage is never cleared, so the head is masked to zero while empty.
   assign rd_valid_o = !empty;
   assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign level_o    = level_q;
   assign afull_o    = (level_q >= PW'(AFULL_LVL));
   assign overrun_o  = overrun_q;

`ifdef UART_RX_FIFO_OVR_CNT_EN
   logic [7:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
         ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign ovr_cnt_o = ovr_cnt_q;
`else
   assign ovr_cnt_o = '0;
`endif
endmodule
